// File: rtl/stage2_partial_sum_pkg.sv
// Shared defaults and state encoding for the stage-2 partial-sum pipeline stage.
package stage2_partial_sum_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  // Output/skid occupancy: EMPTY = nothing held, ONE = output only, FULL = output + skid.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/stage2_partial_sum_pair_adder.sv
// Combinational WIDTH-bit adder with carry-out.
module pair_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full_sum;

  // Extend by one bit so the MSB captures the carry-out.
  always_comb begin
    full_sum = {1'b0, x} + {1'b0, y};
    sum      = full_sum[WIDTH-1:0];
    carry    = full_sum[WIDTH];
  end

endmodule

// File: rtl/stage2_partial_sum.sv
// Stage-2 partial sums (a+b, c+d) behind a 2-entry skid buffer with registered in_ready.
module stage2_partial_sum
  import stage2_partial_sum_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] p0_reg,
  output logic [WIDTH-1:0] p1_reg,
  output logic             c0_reg,
  output logic             c1_reg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] accepted_count
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] new_p0, new_p1;
  logic             new_c0, new_c1;

  logic [WIDTH-1:0] skid_p0, skid_p1;
  logic             skid_c0, skid_c1;

  logic accept, consume;
  logic load_out_new, load_out_skid, load_skid;

  pair_adder #(.WIDTH(WIDTH)) u_add_ab (
    .x     (a),
    .y     (b),
    .sum   (new_p0),
    .carry (new_c0)
  );

  pair_adder #(.WIDTH(WIDTH)) u_add_cd (
    .x     (c),
    .y     (d),
    .sum   (new_p1),
    .carry (new_c1)
  );

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Next-state and datapath load selects for the output/skid pair.
  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          load_out_new = 1'b1;
          state_d      = StOne;
        end
      end
      StOne: begin
        if (accept && consume) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = StFull;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a drain can happen.
        if (consume) begin
          load_out_skid = 1'b1;
          state_d       = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State, handshake and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StEmpty;
      in_ready       <= 1'b1;
      accepted_count <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != StFull);
      if (accept) begin
        accepted_count <= accepted_count + CNT_W'(1);
      end
    end
  end

  // Output register: fresh result or skid drain; holds its value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_reg <= '0;
      p1_reg <= '0;
      c0_reg <= 1'b0;
      c1_reg <= 1'b0;
    end else if (load_out_new) begin
      p0_reg <= new_p0;
      p1_reg <= new_p1;
      c0_reg <= new_c0;
      c1_reg <= new_c1;
    end else if (load_out_skid) begin
      p0_reg <= skid_p0;
      p1_reg <= skid_p1;
      c0_reg <= skid_c0;
      c1_reg <= skid_c1;
    end
  end

  // Skid register: captures a result accepted while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_p0 <= '0;
      skid_p1 <= '0;
      skid_c0 <= 1'b0;
      skid_c1 <= 1'b0;
    end else if (load_skid) begin
      skid_p0 <= new_p0;
      skid_p1 <= new_p1;
      skid_c0 <= new_c0;
      skid_c1 <= new_c1;
    end
  end

endmodule

// File: tb/tb_stage2_partial_sum.sv
// Directed self-checking bench for stage2_partial_sum.
module tb_stage2_partial_sum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, c, d;
  logic [7:0] p0_reg, p1_reg;
  logic       c0_reg, c1_reg;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] accepted_count;

  // Second instance with a narrow counter so the wrap can be reached quickly.
  logic       s_in_ready, s_c0, s_c1, s_out_valid;
  logic [7:0] s_p0, s_p1;
  logic [3:0] s_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stage2_partial_sum #(.WIDTH(8), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .p0_reg         (p0_reg),
    .p1_reg         (p1_reg),
    .c0_reg         (c0_reg),
    .c1_reg         (c1_reg),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .accepted_count (accepted_count)
  );

  stage2_partial_sum #(.WIDTH(8), .CNT_W(4)) dut_small (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (s_in_ready),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .p0_reg         (s_p0),
    .p1_reg         (s_p1),
    .c0_reg         (s_c0),
    .c1_reg         (s_c1),
    .out_valid      (s_out_valid),
    .out_ready      (out_ready),
    .accepted_count (s_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] vc, input logic [7:0] vd);
    in_valid = 1'b1;
    a = va;
    b = vb;
    c = vc;
    d = vd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 8'hAA; b = 8'hAA; c = 8'hAA; d = 8'hAA;
    step();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || p0_reg !== 8'h00 || p1_reg !== 8'h00
        || c0_reg !== 1'b0 || c1_reg !== 1'b0 || accepted_count !== 16'd0)
      $display("FAIL reset: vld=%b rdy=%b p0=%h p1=%h c0=%b c1=%b cnt=%0d (want 0 1 00 00 0 0 0)",
               out_valid, in_ready, p0_reg, p1_reg, c0_reg, c1_reg, accepted_count);
    else passed++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(8'h12, 8'h34, 8'hF0, 8'h20);
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || p0_reg !== 8'h46 || c0_reg !== 1'b0 || p1_reg !== 8'h10
        || c1_reg !== 1'b1 || accepted_count !== 16'd1)
      $display("FAIL basic: vld=%b p0=%h c0=%b p1=%h c1=%b cnt=%0d (want 1 46 0 10 1 1)",
               out_valid, p0_reg, c0_reg, p1_reg, c1_reg, accepted_count);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL basic_drain: out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] va, vb, vc, vd;
    logic [8:0] s0, s1;
    int errs = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      va = 8'(i * 13);
      vb = 8'(200 + i);
      vc = 8'(8'hF0 + i);
      vd = 8'(i * 3);
      s0 = {1'b0, va} + {1'b0, vb};
      s1 = {1'b0, vc} + {1'b0, vd};
      if (in_ready !== 1'b1) begin
        errs++;
        $display("FAIL stream_ready[%0d]: in_ready=%b want 1", i, in_ready);
      end
      drive(va, vb, vc, vd);
      step();
      if (out_valid !== 1'b1 || p0_reg !== s0[7:0] || c0_reg !== s0[8]
          || p1_reg !== s1[7:0] || c1_reg !== s1[8]) begin
        errs++;
        $display("FAIL stream[%0d]: vld=%b p0=%h c0=%b p1=%h c1=%b want 1 %h %b %h %b",
                 i, out_valid, p0_reg, c0_reg, p1_reg, c1_reg, s0[7:0], s0[8], s1[7:0], s1[8]);
      end
    end
    in_valid = 1'b0;
    total++;
    if (errs == 0) passed++;
    total++;
    if (accepted_count !== 16'd21)
      $display("FAIL stream_count: cnt=%0d want 21", accepted_count);
    else passed++;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(8'h01, 8'h01, 8'h10, 8'h10);  // set 1: 02 / 20
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || p0_reg !== 8'h02)
      $display("FAIL bp_first: rdy=%b vld=%b p0=%h want 1 1 02", in_ready, out_valid, p0_reg);
    else passed++;
    drive(8'h02, 8'h02, 8'h20, 8'h20);  // set 2: 04 / 40
    step();
    total++;
    if (in_ready !== 1'b0 || p0_reg !== 8'h02)
      $display("FAIL bp_full: rdy=%b p0=%h want 0 02", in_ready, p0_reg);
    else passed++;
    drive(8'h03, 8'h03, 8'h30, 8'h30);  // set 3: 06 / 60, must be held
    step();
    total++;
    if (accepted_count !== 16'd23 || in_ready !== 1'b0 || p0_reg !== 8'h02 || p1_reg !== 8'h20)
      $display("FAIL bp_hold: cnt=%0d rdy=%b p0=%h p1=%h want 23 0 02 20",
               accepted_count, in_ready, p0_reg, p1_reg);
    else passed++;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || p0_reg !== 8'h04 || p1_reg !== 8'h40 || in_ready !== 1'b1)
      $display("FAIL bp_second: vld=%b p0=%h p1=%h rdy=%b want 1 04 40 1",
               out_valid, p0_reg, p1_reg, in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || p0_reg !== 8'h06 || p1_reg !== 8'h60 || accepted_count !== 16'd24)
      $display("FAIL bp_third: vld=%b p0=%h p1=%h cnt=%0d want 1 06 60 24",
               out_valid, p0_reg, p1_reg, accepted_count);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_boundary();
    out_ready = 1'b1;
    drive(8'hFF, 8'h01, 8'hFF, 8'hFF);
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || p0_reg !== 8'h00 || c0_reg !== 1'b1 || p1_reg !== 8'hFE
        || c1_reg !== 1'b1)
      $display("FAIL boundary: vld=%b p0=%h c0=%b p1=%h c1=%b want 1 00 1 fe 1",
               out_valid, p0_reg, c0_reg, p1_reg, c1_reg);
    else passed++;
    step();
  endtask

  task automatic test_reset_in_full();
    out_ready = 1'b0;
    drive(8'h11, 8'h11, 8'h11, 8'h11);
    step();
    drive(8'h55, 8'h55, 8'h55, 8'h55);
    step();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL rstfull_setup: rdy=%b vld=%b want 0 1", in_ready, out_valid);
    else passed++;
    rst = 1'b1;
    drive(8'h77, 8'h77, 8'h77, 8'h77);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || p0_reg !== 8'h00 || p1_reg !== 8'h00
        || accepted_count !== 16'd0)
      $display("FAIL rstfull: vld=%b rdy=%b p0=%h p1=%h cnt=%0d want 0 1 00 00 0",
               out_valid, in_ready, p0_reg, p1_reg, accepted_count);
    else passed++;
    out_ready = 1'b1;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || p0_reg !== 8'h00)
      $display("FAIL rstfull_noskid: vld=%b p0=%h want 0 00", out_valid, p0_reg);
    else passed++;
  endtask

  task automatic test_count_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(8'(i), 8'h01, 8'h02, 8'h03);
      step();
    end
    total++;
    if (s_count !== 4'hF)
      $display("FAIL wrap_max: cnt=%h want f", s_count);
    else passed++;
    drive(8'h40, 8'h01, 8'h02, 8'h03);
    step();
    in_valid = 1'b0;
    total++;
    if (s_count !== 4'h0 || accepted_count !== 16'd16)
      $display("FAIL wrap: small=%h main=%0d want 0 16", s_count, accepted_count);
    else passed++;
    step();
  endtask

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_boundary();
    test_reset_in_full();
    test_count_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
